// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared lc3b memory-stage types and constants
//
// Purpose: memory operation encoding used by the ex_mem stage and the
// data-access sequencer, the default pointer-chase depth, and the decoded
// access phase of the sequencer.
// Ports: none (package).

package lc3b_types;

  typedef enum logic [2:0] {
    MEM_LDW = 3'd0,
    MEM_STW = 3'd1,
    MEM_LDB = 3'd2,
    MEM_STB = 3'd3,
    MEM_LDI = 3'd4,
    MEM_STI = 3'd5
  } lc3b_mem_op;

  localparam int MEM_IND_LEVELS_DEFAULT = 1;

  // Which kind of d-cache access the sequencer is making this cycle.
  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_POINTER = 2'd1,
    PH_FINAL   = 2'd2
  } seq_phase_t;

endpackage

// File: rtl/mem_access_sequencer_byte_lane_unit.sv
// rtl/mem_access_sequencer_byte_lane_unit.sv - byte-lane formatting for d-cache accesses
//
// Purpose: combinational byte-lane glue. Generates byte enables, replicates
// the store byte onto both lanes for STB, and extracts/zero-extends the
// addressed byte for LDB. Word accesses pass straight through.
// Ports:
//   byte_op    in   1      access is a byte access (LDB/STB final phase)
//   addr_lsb   in   1      address bit 0, selects the high or low lane
//   wdata_in   in   WIDTH  raw store data
//   rdata_in   in   WIDTH  raw d-cache read data
//   byte_en    out  2      [1]=high byte, [0]=low byte
//   wdata_out  out  WIDTH  store data placed on the lanes
//   load_data  out  WIDTH  formatted load result

module byte_lane_unit #(
  parameter int WIDTH = 16
) (
  input  logic             byte_op,
  input  logic             addr_lsb,
  input  logic [WIDTH-1:0] wdata_in,
  input  logic [WIDTH-1:0] rdata_in,
  output logic [1:0]       byte_en,
  output logic [WIDTH-1:0] wdata_out,
  output logic [WIDTH-1:0] load_data
);

  always_comb begin
    byte_en   = 2'b11;
    wdata_out = wdata_in;
    load_data = rdata_in;
    if (byte_op) begin
      byte_en         = addr_lsb ? 2'b10 : 2'b01;
      // The cache picks the lane via byte_en, so drive the byte on both.
      wdata_out       = '0;
      wdata_out[15:0] = {wdata_in[7:0], wdata_in[7:0]};
      load_data       = '0;
      load_data[7:0]  = addr_lsb ? rdata_in[15:8] : rdata_in[7:0];
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - lc3b memory-stage data-access sequencer
//
// Purpose: issues word/byte loads and stores and N-level indirect
// (pointer-chasing) LDI/STI accesses to the d-cache, stalling the pipeline
// until the final access of a request completes.
// Ports:
//   clk, reset    in   1      clock, synchronous active-high reset
//   req_valid     in   1      request present (held stable while stall=1)
//   req_op        in   3      lc3b_mem_op
//   req_addr      in   WIDTH  effective address
//   req_wdata     in   WIDTH  store data
//   mem_resp      in   1      d-cache response (may be same cycle)
//   mem_rdata     in   WIDTH  d-cache read data
//   mem_address   out  WIDTH  d-cache address
//   mem_read      out  1      d-cache read strobe
//   mem_write     out  1      d-cache write strobe
//   mem_byte_en   out  2      byte enables
//   mem_wdata     out  WIDTH  d-cache write data
//   load_data     out  WIDTH  formatted load result, valid with done
//   stall         out  1      hold IF/ID/EX/MEM
//   done          out  1      final access completes this cycle

module mem_access_sequencer
  import lc3b_types::*;
#(
  parameter int WIDTH      = 16,
  parameter int IND_LEVELS = MEM_IND_LEVELS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic             mem_resp,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_address,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       mem_byte_en,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] load_data,
  output logic             stall,
  output logic             done
);

  localparam int LVL_W = $clog2(IND_LEVELS + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(IND_LEVELS);

  logic [LVL_W-1:0] lvl;
  logic [WIDTH-1:0] ptr;

  lc3b_mem_op       op;
  seq_phase_t       phase;
  logic             is_ind;
  logic             is_byte;
  logic             is_store;
  logic [WIDTH-1:0] cur_addr;
  logic [1:0]       lane_be;
  logic [WIDTH-1:0] lane_wdata;

  assign op = lc3b_mem_op'(req_op);

  // Phase decode. Undefined op codes fall into the final phase as word reads
  // so that exactly one strobe is still raised.
  always_comb begin
    is_ind   = (op == MEM_LDI) || (op == MEM_STI);
    is_byte  = (op == MEM_LDB) || (op == MEM_STB);
    is_store = (op == MEM_STW) || (op == MEM_STB) || (op == MEM_STI);
    cur_addr = (lvl == '0) ? req_addr : ptr;
    if (!req_valid) begin
      phase = PH_IDLE;
    end else if (is_ind && (lvl < LVL_MAX)) begin
      phase = PH_POINTER;
    end else begin
      phase = PH_FINAL;
    end
  end

  byte_lane_unit #(.WIDTH(WIDTH)) u_lanes (
    .byte_op   (is_byte && (phase != PH_POINTER)),
    .addr_lsb  (cur_addr[0]),
    .wdata_in  (req_wdata),
    .rdata_in  (mem_rdata),
    .byte_en   (lane_be),
    .wdata_out (lane_wdata),
    .load_data (load_data)
  );

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    done        = 1'b0;
    mem_address = {cur_addr[WIDTH-1:1], 1'b0};
    mem_byte_en = lane_be;
    mem_wdata   = lane_wdata;
    case (phase)
      PH_POINTER: begin
        mem_read = 1'b1;
      end
      PH_FINAL: begin
        mem_read  = ~is_store;
        mem_write = is_store;
        if (is_byte) begin
          mem_address = cur_addr;
        end
        done = mem_resp;
      end
      default: ;
    endcase
    stall = req_valid & ~done;
  end

  // The level counter doubles as the sequencer state: 0 means a fresh
  // request, anything below LVL_MAX on LDI/STI means more pointers to chase.
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl <= '0;
      ptr <= '0;
    end else begin
      case (phase)
        PH_IDLE: begin
          lvl <= '0;
        end
        PH_POINTER: begin
          if (mem_resp) begin
            ptr <= mem_rdata;
            lvl <= lvl + LVL_W'(1);
          end
        end
        PH_FINAL: begin
          if (mem_resp) begin
            lvl <= '0;
          end
        end
        default: begin
          lvl <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - self-checking bench for mem_access_sequencer

module tb_mem_access_sequencer;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic reset;

  // Index 0: IND_LEVELS=1, index 1: IND_LEVELS=3.
  logic [1:0]            rv;
  logic [1:0][2:0]       rop;
  logic [1:0][15:0]      raddr;
  logic [1:0][15:0]      rwdata;
  logic [1:0]            mresp;
  logic [1:0][15:0]      mrdata;
  logic [1:0][15:0]      maddr;
  logic [1:0]            mrd;
  logic [1:0]            mwr;
  logic [1:0][1:0]       mbe;
  logic [1:0][15:0]      mwdata;
  logic [1:0][15:0]      ldata;
  logic [1:0]            stl;
  logic [1:0]            dn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_sequencer #(.WIDTH(16), .IND_LEVELS(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_op(rop[0]),
    .req_addr(raddr[0]), .req_wdata(rwdata[0]), .mem_resp(mresp[0]),
    .mem_rdata(mrdata[0]), .mem_address(maddr[0]), .mem_read(mrd[0]),
    .mem_write(mwr[0]), .mem_byte_en(mbe[0]), .mem_wdata(mwdata[0]),
    .load_data(ldata[0]), .stall(stl[0]), .done(dn[0])
  );

  mem_access_sequencer #(.WIDTH(16), .IND_LEVELS(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_op(rop[1]),
    .req_addr(raddr[1]), .req_wdata(rwdata[1]), .mem_resp(mresp[1]),
    .mem_rdata(mrdata[1]), .mem_address(maddr[1]), .mem_read(mrd[1]),
    .mem_write(mwr[1]), .mem_byte_en(mbe[1]), .mem_wdata(mwdata[1]),
    .load_data(ldata[1]), .stall(stl[1]), .done(dn[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got 0x%0h expected 0x%0h", name, d, $time, act, exp);
    end
  endtask

  task automatic start(input int d, input lc3b_mem_op op, input logic [15:0] addr, input logic [15:0] wdata);
    rv[d]     = 1'b1;
    rop[d]    = op;
    raddr[d]  = addr;
    rwdata[d] = wdata;
  endtask

  // One d-cache access lasting lat+1 cycles; the response arrives in the last.
  task automatic access(input int d, input bit exp_rd, input logic [15:0] exp_addr,
                        input logic [1:0] exp_be, input logic [15:0] exp_wd,
                        input logic [15:0] rdata, input int lat, input bit is_final,
                        input bit chk_load, input logic [15:0] exp_load);
    for (int c = 0; c <= lat; c++) begin
      mresp[d]  = (c == lat);
      mrdata[d] = (c == lat) ? rdata : 16'($urandom);
      @(negedge clk);
      chk("mem_read", d, 32'(mrd[d]), 32'(exp_rd));
      chk("mem_write", d, 32'(mwr[d]), 32'(!exp_rd));
      chk("mem_address", d, 32'(maddr[d]), 32'(exp_addr));
      chk("mem_byte_en", d, 32'(mbe[d]), 32'(exp_be));
      if (!exp_rd) chk("mem_wdata", d, 32'(mwdata[d]), 32'(exp_wd));
      chk("done", d, 32'(dn[d]), 32'(is_final && (c == lat)));
      chk("stall", d, 32'(stl[d]), 32'(!(is_final && (c == lat))));
      if (chk_load && is_final && (c == lat)) chk("load_data", d, 32'(ldata[d]), 32'(exp_load));
      @(posedge clk);
      #1;
    end
    mresp[d] = 1'b0;
  endtask

  // req_valid low: responses arriving now must be ignored and nothing strobes.
  task automatic idle(input int d, input int n);
    rv[d] = 1'b0;
    for (int c = 0; c < n; c++) begin
      mresp[d]  = 1'($urandom);
      mrdata[d] = 16'($urandom);
      @(negedge clk);
      chk("idle_read", d, 32'(mrd[d]), 32'd0);
      chk("idle_write", d, 32'(mwr[d]), 32'd0);
      chk("idle_stall", d, 32'(stl[d]), 32'd0);
      chk("idle_done", d, 32'(dn[d]), 32'd0);
      @(posedge clk);
      #1;
    end
    mresp[d] = 1'b0;
  endtask

  // Reference model: walks the pointer chain with random pointer values and
  // derives the expected final access from the op's rules.
  task automatic run_txn(input int d, input lc3b_mem_op op, input logic [15:0] addr, input logic [15:0] wdata);
    int          levels;
    logic [15:0] cur;
    logic [15:0] p;
    logic [15:0] r;
    logic [15:0] ea;
    logic [15:0] wd;
    logic [15:0] ld;
    logic [1:0]  be;
    bit          is_byte;
    bit          rd;
    levels = (op == MEM_LDI || op == MEM_STI) ? ((d == 0) ? 1 : 3) : 0;
    start(d, op, addr, wdata);
    cur = addr;
    for (int i = 0; i < levels; i++) begin
      p = 16'($urandom);
      access(d, 1'b1, {cur[15:1], 1'b0}, 2'b11, 16'h0, p, $urandom_range(0, 3), 1'b0, 1'b0, 16'h0);
      cur = p;
    end
    is_byte = (op == MEM_LDB) || (op == MEM_STB);
    rd      = (op == MEM_LDW) || (op == MEM_LDB) || (op == MEM_LDI);
    ea      = is_byte ? cur : {cur[15:1], 1'b0};
    be      = is_byte ? (cur[0] ? 2'b10 : 2'b01) : 2'b11;
    wd      = (op == MEM_STB) ? {wdata[7:0], wdata[7:0]} : wdata;
    r       = 16'($urandom);
    ld      = (op == MEM_LDB) ? (cur[0] ? {8'h00, r[15:8]} : {8'h00, r[7:0]}) : r;
    access(d, rd, ea, be, wd, r, $urandom_range(0, 3), 1'b1, rd, ld);
  endtask

  typedef struct {
    lc3b_mem_op  op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          lat;
    bit          rd;
    logic [15:0] exp_addr;
    logic [1:0]  exp_be;
    logic [15:0] exp_wd;
    logic [15:0] exp_load;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{MEM_LDW, 16'h1003, 16'h0000, 16'hBEEF, 0, 1'b1, 16'h1002, 2'b11, 16'h0000, 16'hBEEF};
    tbl[1] = '{MEM_STB, 16'h2001, 16'h12A5, 16'h0000, 3, 1'b0, 16'h2001, 2'b10, 16'hA5A5, 16'h0000};
    tbl[2] = '{MEM_LDB, 16'h5001, 16'h0000, 16'h80FF, 1, 1'b1, 16'h5001, 2'b10, 16'h0000, 16'h0080};
    tbl[3] = '{MEM_LDB, 16'h5000, 16'h0000, 16'h80FF, 0, 1'b1, 16'h5000, 2'b01, 16'h0000, 16'h00FF};
    tbl[4] = '{MEM_STW, 16'h2003, 16'h1234, 16'h0000, 2, 1'b0, 16'h2002, 2'b11, 16'h1234, 16'h0000};
    tbl[5] = '{MEM_STB, 16'h2000, 16'h3377, 16'h0000, 0, 1'b0, 16'h2000, 2'b01, 16'h7777, 16'h0000};
    tbl[6] = '{MEM_LDW, 16'hFFFF, 16'h0000, 16'h8001, 2, 1'b1, 16'hFFFE, 2'b11, 16'h0000, 16'h8001};

    reset  = 1'b1;
    rv     = '0;
    rop    = '0;
    raddr  = '0;
    rwdata = '0;
    mresp  = '0;
    mrdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    idle(0, 1);
    idle(1, 1);

    // Direct ops, back-to-back with no idle gap between vectors.
    for (int i = 0; i < 7; i++) begin
      start(0, tbl[i].op, tbl[i].addr, tbl[i].wdata);
      access(0, tbl[i].rd, tbl[i].exp_addr, tbl[i].exp_be, tbl[i].exp_wd,
             tbl[i].rdata, tbl[i].lat, 1'b1, tbl[i].rd, tbl[i].exp_load);
    end
    idle(0, 1);

    // LDI, one level: 0x3000 -> 0x4000 -> 0x0042.
    start(0, MEM_LDI, 16'h3000, 16'h0);
    access(0, 1'b1, 16'h3000, 2'b11, 16'h0, 16'h4000, 1, 1'b0, 1'b0, 16'h0);
    access(0, 1'b1, 16'h4000, 2'b11, 16'h0, 16'h0042, 2, 1'b1, 1'b1, 16'h0042);
    idle(0, 1);

    // STI, three levels: 0x10 -> 0x20 -> 0x30 -> 0x40, write at 0x40.
    start(1, MEM_STI, 16'h0010, 16'hCAFE);
    access(1, 1'b1, 16'h0010, 2'b11, 16'h0, 16'h0020, 0, 1'b0, 1'b0, 16'h0);
    access(1, 1'b1, 16'h0020, 2'b11, 16'h0, 16'h0030, 1, 1'b0, 1'b0, 16'h0);
    access(1, 1'b1, 16'h0030, 2'b11, 16'h0, 16'h0040, 0, 1'b0, 1'b0, 16'h0);
    access(1, 1'b0, 16'h0040, 2'b11, 16'hCAFE, 16'h0, 1, 1'b1, 1'b0, 16'h0);
    idle(1, 1);

    // Squash after the first pointer response, then a fresh LDW.
    start(0, MEM_LDI, 16'h3000, 16'h0);
    access(0, 1'b1, 16'h3000, 2'b11, 16'h0, 16'h4000, 0, 1'b0, 1'b0, 16'h0);
    idle(0, 1);
    start(0, MEM_LDW, 16'h6000, 16'h0);
    access(0, 1'b1, 16'h6000, 2'b11, 16'h0, 16'h5555, 0, 1'b1, 1'b1, 16'h5555);
    idle(0, 1);

    // Reset after the first pointer response with a response pending.
    start(0, MEM_LDI, 16'h3000, 16'h0);
    access(0, 1'b1, 16'h3000, 2'b11, 16'h0, 16'h4000, 0, 1'b0, 1'b0, 16'h0);
    reset     = 1'b1;
    mresp[0]  = 1'b1;
    mrdata[0] = 16'h9999;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    mresp[0] = 1'b0;
    access(0, 1'b1, 16'h3000, 2'b11, 16'h0, 16'h4001, 1, 1'b0, 1'b0, 16'h0);
    access(0, 1'b1, 16'h4000, 2'b11, 16'h0, 16'h1357, 0, 1'b1, 1'b1, 16'h1357);
    start(0, MEM_LDW, 16'h6000, 16'h0);
    access(0, 1'b1, 16'h6000, 2'b11, 16'h0, 16'h2468, 1, 1'b1, 1'b1, 16'h2468);
    idle(0, 1);

    // Randomized transactions against the reference model.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        run_txn(d, lc3b_mem_op'(3'($urandom_range(0, 5))), 16'($urandom), 16'($urandom));
        if ($urandom_range(0, 2) != 0) idle(d, $urandom_range(1, 2));
      end
      idle(d, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
